// File: rtl/scr1_accel_master.sv
// Sequences one multiply-accelerator operation over the SCR1 dmem interface:
// write A, write B, write GO, poll STATUS until DONE, read RESULT.
// The memory-interface type package is kept in this file so the block is
// self-contained.

package scr1_memif_pkg;
  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

// state    | meaning
// IDLE     | waiting for start, dmem_resp not sampled
// WR_A     | write operand A to DATA_A
// WR_B     | write operand B to DATA_B
// WR_GO    | write 1 to CTRL to launch the multiply
// RD_STAT  | read STATUS, reissue until DONE or poll limit
// RD_RES   | read RESULT, then done pulse
// Each bus state has a REQ phase (rsp_phase=0) and a RSP phase (rsp_phase=1).
module scr1_accel_master
  import scr1_memif_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_POLLS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          op_a,
  input  logic [31:0]          op_b,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [31:0]          result,
  output logic                 dmem_req,
  input  logic                 dmem_req_ack,
  output type_scr1_mem_cmd_e   dmem_cmd,
  output type_scr1_mem_width_e dmem_width,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  type_scr1_mem_resp_e  dmem_resp
);

  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h00;
  localparam logic [31:0] ADDR_DATA_A = BASE_ADDR + 32'h08;
  localparam logic [31:0] ADDR_DATA_B = BASE_ADDR + 32'h0C;
  localparam logic [31:0] ADDR_RESULT = BASE_ADDR + 32'h10;
  localparam logic [15:0] POLL_LAST   = 16'(MAX_POLLS - 1);

  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_GO,
    ST_RD_STAT,
    ST_RD_RES
  } state_e;

  state_e      state;
  logic        rsp_phase;
  logic [31:0] op_b_q;
  logic [15:0] poll_cnt;

  assign dmem_width = SCR1_MEM_WIDTH_WORD;

  // Sequencer: every bus output is registered; cmd/addr/wdata only change when a new REQ is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rsp_phase  <= 1'b0;
      op_b_q     <= '0;
      poll_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      result     <= '0;
      dmem_req   <= 1'b0;
      dmem_cmd   <= SCR1_MEM_CMD_RD;
      dmem_addr  <= BASE_ADDR;
      dmem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          state      <= ST_WR_A;
          rsp_phase  <= 1'b0;
          busy       <= 1'b1;
          err_code   <= 2'b00;
          op_b_q     <= op_b;
          dmem_req   <= 1'b1;
          dmem_cmd   <= SCR1_MEM_CMD_WR;
          dmem_addr  <= ADDR_DATA_A;
          dmem_wdata <= op_a;
        end
      end else if (!rsp_phase) begin
        // dmem_req is always high in REQ, so the handshake reduces to ack.
        if (dmem_req_ack) begin
          dmem_req  <= 1'b0;
          rsp_phase <= 1'b1;
        end
      end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
        state     <= ST_IDLE;
        rsp_phase <= 1'b0;
        busy      <= 1'b0;
        err       <= 1'b1;
        err_code  <= ERR_BUS;
      end else if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
        rsp_phase <= 1'b0;
        case (state)
          ST_WR_A: begin
            state      <= ST_WR_B;
            dmem_req   <= 1'b1;
            dmem_addr  <= ADDR_DATA_B;
            dmem_wdata <= op_b_q;
          end
          ST_WR_B: begin
            state      <= ST_WR_GO;
            dmem_req   <= 1'b1;
            dmem_addr  <= ADDR_CTRL;
            dmem_wdata <= 32'h0000_0001;
          end
          ST_WR_GO: begin
            state      <= ST_RD_STAT;
            poll_cnt   <= '0;
            dmem_req   <= 1'b1;
            dmem_cmd   <= SCR1_MEM_CMD_RD;
            dmem_addr  <= ADDR_CTRL;
            dmem_wdata <= '0;
          end
          ST_RD_STAT: begin
            if (dmem_rdata[31]) begin
              state     <= ST_RD_RES;
              dmem_req  <= 1'b1;
              dmem_addr <= ADDR_RESULT;
            end else if (poll_cnt == POLL_LAST) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
              dmem_req <= 1'b1;
            end
          end
          ST_RD_RES: begin
            state  <= ST_IDLE;
            result <= dmem_rdata;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scr1_accel_master.sv
// Bench for scr1_accel_master: behavioural accelerator slave with configurable
// wait states, error injection and DONE latency; scoreboard of expected
// done/err outcomes checked by an independent monitor; bus trace compared
// against the expected register access sequence.
module tb_scr1_accel_master;
  import scr1_memif_pkg::*;

  localparam int          MAXP = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [31:0]          op_a = '0;
  logic [31:0]          op_b = '0;
  logic                 busy, done, err;
  logic [1:0]           err_code;
  logic [31:0]          result;
  logic                 dmem_req;
  logic                 dmem_req_ack;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr, dmem_wdata, dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;

  scr1_accel_master #(.BASE_ADDR(BASE), .MAX_POLLS(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .result(result),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [1:0]  kind;   // 01 done, 10 err
    logic [1:0]  code;
    logic [31:0] res;
  } exp_t;

  txn_t trace_q[$];
  txn_t ref_q[$];
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  int ack_wait = 0, rsp_wait = 0, err_at = 99, done_after = 0;
  int txn_idx = 0, rst_gen = 0;
  logic [31:0] acc_a = '0, acc_b = '0, acc_res = '0;
  int acc_polls = 0;
  logic [31:0] last_result = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) rst_gen++;

  // Accelerator register model reacting to one completed bus access.
  task automatic slave_access(input logic c, input logic [31:0] a, input logic [31:0] w);
    dmem_rdata = $urandom;
    if (c) begin
      if (a == BASE + 32'h08) acc_a = w;
      else if (a == BASE + 32'h0C) acc_b = w;
      else if (a == BASE && w[0]) begin
        acc_res   = acc_a * acc_b;
        acc_polls = 0;
      end
    end else if (a == BASE) begin
      if (acc_polls >= done_after) dmem_rdata = {1'b1, 31'($urandom)};
      else begin
        dmem_rdata = {1'b0, 31'($urandom)};
        acc_polls++;
      end
    end else if (a == BASE + 32'h10) begin
      dmem_rdata = acc_res;
    end
  endtask

  // Slave: ack after ack_wait cycles, respond rsp_wait cycles after the cycle following acceptance.
  initial begin
    int g;
    logic c;
    logic [31:0] a, w;
    dmem_req_ack = 1'b0;
    dmem_resp    = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata   = '0;
    @(negedge clk);
    forever begin
      dmem_req_ack = 1'b0;
      dmem_resp    = SCR1_MEM_RESP_NOTRDY;
      if (rst_n && dmem_req) begin
        g = rst_gen;
        repeat (ack_wait) @(negedge clk);
        dmem_req_ack = 1'b1;
        c = dmem_cmd;
        a = dmem_addr;
        w = dmem_wdata;
        @(negedge clk);
        dmem_req_ack = 1'b0;
        repeat (rsp_wait) @(negedge clk);
        if (g == rst_gen) begin
          chk("hold_addr", dmem_addr, a);
          chk("hold_cmd", dmem_cmd, c);
          chk("hold_wdata", dmem_wdata, w);
          trace_q.push_back('{c, a, w});
          if (txn_idx == err_at) begin
            dmem_resp  = SCR1_MEM_RESP_RDY_ER;
            dmem_rdata = $urandom;
          end else begin
            dmem_resp = SCR1_MEM_RESP_RDY_OK;
            slave_access(c, a, w);
          end
        end else begin
          dmem_resp = SCR1_MEM_RESP_RDY_OK;
        end
        txn_idx++;
      end
      @(negedge clk);
    end
  end

  // Monitor: every done/err pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {done, err}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("outcome_kind", {err, done}, e.kind);
        chk("err_code", err_code, e.code);
        chk("result", result, e.res);
      end
    end
  end

  // Reference: expected access sequence and outcome from the operation rules.
  task automatic model_op(input logic [31:0] a, input logic [31:0] b);
    int polls;
    bit timeout;
    ref_q.delete();
    ref_q.push_back('{1'b1, BASE + 32'h08, a});
    ref_q.push_back('{1'b1, BASE + 32'h0C, b});
    ref_q.push_back('{1'b1, BASE, 32'h1});
    timeout = (done_after >= MAXP);
    polls = timeout ? MAXP : done_after + 1;
    repeat (polls) ref_q.push_back('{1'b0, BASE, 32'h0});
    if (!timeout) ref_q.push_back('{1'b0, BASE + 32'h10, 32'h0});
    if (err_at < ref_q.size()) begin
      while (ref_q.size() > err_at + 1) void'(ref_q.pop_back());
      exp_q.push_back('{2'b10, 2'b01, last_result});
    end else if (timeout) begin
      exp_q.push_back('{2'b10, 2'b10, last_result});
    end else begin
      last_result = a * b;
      exp_q.push_back('{2'b01, 2'b00, last_result});
    end
  endtask

  // Issue start at the current negedge and follow the operation to its done/err cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit repulse);
    int cnt, per, n;
    trace_q.delete();
    txn_idx = 0;
    model_op(a, b);
    per = ack_wait + rsp_wait + 2;
    start = 1'b1;
    op_a = a;
    op_b = b;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    cnt = 1;
    chk("busy_rise", busy, 1);
    chk("req_rise", dmem_req, 1);
    while (!(done || err) && cnt < 2000) begin
      if (repulse && cnt == 3 * per + 2) begin
        start = 1'b1;
        op_a = $urandom;
        op_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk("finish_seen", done | err, 1);
    chk("latency", cnt, 1 + ref_q.size() * per);
    chk("busy_fall", busy, 0);
    chk("trace_len", trace_q.size(), ref_q.size());
    n = (trace_q.size() < ref_q.size()) ? trace_q.size() : ref_q.size();
    for (int i = 0; i < n; i++) begin
      chk("trace_cmd", trace_q[i].cmd, ref_q[i].cmd);
      chk("trace_addr", trace_q[i].addr, ref_q[i].addr);
      if (ref_q[i].cmd) chk("trace_wdata", trace_q[i].wdata, ref_q[i].wdata);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req", dmem_req, 0);
    chk("rst_cmd", dmem_cmd, SCR1_MEM_CMD_RD);
    chk("rst_width", dmem_width, SCR1_MEM_WIDTH_WORD);
    chk("rst_addr", dmem_addr, BASE);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_result", result, 0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait slave, DONE on third poll.
    ack_wait = 0; rsp_wait = 0; err_at = 99; done_after = 2;
    run_op(32'h0000_00FF, 32'h0000_0002, 1'b0);
    repeat (2) @(negedge clk);

    // Slow slave: ack after 3 cycles, response 2 cycles after acceptance.
    ack_wait = 3; rsp_wait = 1;
    run_op(32'h0000_00FF, 32'h0000_0002, 1'b0);
    repeat (2) @(negedge clk);

    // Bus error on WR_B.
    ack_wait = 0; rsp_wait = 0; err_at = 1; done_after = 0;
    run_op(32'h1234_5678, 32'h0000_0003, 1'b0);
    repeat (2) @(negedge clk);

    // DONE never set: poll timeout.
    err_at = 99; done_after = 1000;
    run_op(32'h0000_0007, 32'h0000_0009, 1'b0);
    repeat (2) @(negedge clk);

    // start re-pulsed during polling, then a new start on the done cycle.
    ack_wait = 1; rsp_wait = 0; done_after = 3;
    run_op(32'h0000_1001, 32'h0000_0010, 1'b1);
    done_after = 0;
    run_op(32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    repeat (2) @(negedge clk);

    // Randomized operations.
    for (int k = 0; k < 12; k++) begin
      ack_wait   = $urandom_range(0, 2);
      rsp_wait   = $urandom_range(0, 2);
      done_after = $urandom_range(0, 5);
      err_at     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 99;
      run_op($urandom, $urandom, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset pulsed while polling STATUS.
    ack_wait = 1; rsp_wait = 1; err_at = 99; done_after = 3;
    trace_q.delete();
    txn_idx = 0;
    start = 1'b1; op_a = 32'h0000_0005; op_b = 32'h0000_0006;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (trace_q.size() < 4 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_rd_stat", trace_q.size() >= 4, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    last_result = '0;
    repeat (12) @(negedge clk);
    chk("idle_after_reset", busy, 0);

    ack_wait = 0; rsp_wait = 0; done_after = 1;
    run_op(32'h0000_0011, 32'h0000_0022, 1'b0);
    repeat (3) @(negedge clk);

    chk("pending_outcomes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scr1_accel_master.md
# scr1_accel_master

Bus-initiator sequencer that drives one complete operation on the memory-mapped multiply accelerator over the SCR1 data-memory interface: write operand A, write operand B, write GO, poll STATUS until DONE, read RESULT. It sits between a local control source (test harness or small controller) and the accelerator's dmem port, replacing hand-written core load/store sequences. It keeps one transaction outstanding at a time and reports the result, or an error, to the local side.

## Interface
- BASE_ADDR, 32'h0000_0000, byte base address of accelerator register window
- MAX_POLLS, 16, STATUS reads allowed before timeout error (1..65535)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to run an operation; honoured only in IDLE
- op_a  in  32  operand A, captured on accepted start
- op_b  in  32  operand B, captured on accepted start
- busy  out  1  high from the cycle after accepted start until done/err pulse
- done  out  1  one-cycle pulse, result valid
- err  out  1  one-cycle pulse, operation aborted
- err_code  out  2  01 = bus RDY_ER, 10 = poll timeout; held until next start
- result  out  32  RESULT register value; held until next done
- dmem_req  out  1  request valid
- dmem_req_ack  in  1  request accepted when high with dmem_req
- dmem_cmd  out  type_scr1_mem_cmd_e  RD/WR
- dmem_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD
- dmem_addr  out  32  byte address
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data, valid with RDY_OK
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

## Operation
- Register offsets from BASE_ADDR: STATUS/CTRL 0x00 (bit31 DONE), DATA_A 0x08, DATA_B 0x0C, RESULT 0x10.
- FSM: IDLE -> WR_A -> WR_B -> WR_GO -> RD_STAT -> RD_RES -> IDLE. Each bus state has sub-phases REQ and RSP.
- REQ: dmem_req=1 with cmd/addr/wdata driven; leaves REQ on dmem_req & dmem_req_ack.
- RSP: dmem_req=0; dmem_cmd, dmem_addr, dmem_wdata held at the REQ values until response is sampled (the slave's read data depends on the live address). dmem_resp is ignored in the acceptance cycle; sampled from the next cycle on.
- RSP + RDY_OK: advance. RSP + RDY_ER: abort to IDLE, err pulse, err_code=01.
- WR_GO writes 32'h0000_0001 to CTRL.
- RD_STAT: on RDY_OK, rdata[31]=1 -> RD_RES; else poll counter +1 and reissue. Counter cleared on entering RD_STAT from WR_GO. Reaching MAX_POLLS reads with DONE clear -> abort, err_code=10.
- RD_RES: on RDY_OK latch rdata into result, done pulse, return to IDLE.
- start while busy ignored; op_a/op_b changes after acceptance ignored.
- No timeout on REQ or RSP waits; a stalled slave stalls the block indefinitely.

## Timing
- Reset values: dmem_req=0, dmem_cmd=RD, dmem_width=WORD, dmem_addr=BASE_ADDR, dmem_wdata=0, busy=0, done=0, err=0, err_code=00, result=0, FSM IDLE.
- start sampled at cycle t -> dmem_req=1 for WR_A at t+1, busy=1 at t+1.
- Zero-wait slave (ack=1, RDY_OK one cycle after acceptance): each transaction 2 cycles, next REQ immediately after RSP cycle.
- done/err asserted in the cycle after the terminating response, simultaneously with busy falling; start accepted again the same cycle.
- rst_n assertion mid-operation: immediate return to reset values; any in-flight slave response after reset release is ignored (IDLE does not sample dmem_resp).

## Test plan
- Real accelerator attached, op_a=32'h0000_00FF, op_b=32'h0000_0002, start -> writes 0x08/0x0C/0x00 in order, DONE seen within 3 polls, result=32'h0000_01FE, done pulse, err_code=00.
- Slave model ack low 3 cycles per request, RDY_OK 2 cycles later -> dmem_addr/cmd/wdata stable from REQ through response; same result as zero-wait run.
- Slave returns RDY_ER on WR_B -> no GO write issued, err pulse, err_code=01, busy=0 next cycle.
- Slave never sets DONE, MAX_POLLS=4 -> exactly 4 STATUS reads, err pulse, err_code=10.
- start re-pulsed during polling with different operands -> ignored; result from first operands only; start on the done cycle accepted.
- rst_n pulsed during RD_STAT -> all outputs reset values next cycle; subsequent start completes normally.
